// File: rtl/team_03_bus_arbiter_if.sv
`timescale 1ns/1ps
// Signal bundle for team_03_bus_arbiter: Wishbone requester, logic-analyzer
// requester and the shared downstream register port.
interface team_03_bus_arbiter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        la_req_i;
  logic        la_we_i;
  logic [31:0] la_adr_i;
  logic [31:0] la_dat_i;
  logic        la_ack_o;
  logic [31:0] la_dat_o;

  logic        dev_stb_o;
  logic        dev_we_o;
  logic [3:0]  dev_sel_o;
  logic [31:0] dev_adr_o;
  logic [31:0] dev_dat_o;
  logic        dev_ack_i;
  logic [31:0] dev_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  la_req_i, la_we_i, la_adr_i, la_dat_i,
    output la_ack_o, la_dat_o,
    output dev_stb_o, dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o,
    input  dev_ack_i, dev_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output la_req_i, la_we_i, la_adr_i, la_dat_i,
    input  la_ack_o, la_dat_o,
    input  dev_stb_o, dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o,
    output dev_ack_i, dev_dat_i
  );
endinterface

// File: rtl/team_03_bus_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter between a Wishbone requester and a logic-analyzer
// requester onto one downstream register port, with a per-transfer timeout.
module team_03_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  team_03_bus_arbiter_if.slave  bus,
  output logic                  timeout_o,
  output logic [7:0]            timeout_cnt_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r, state_nxt_s;
  logic        wb_req_s, la_req_s, keep_s, deliver_s;
  logic        grant_s, grant_la_s, done_s, tmo_s;
  logic [31:0] rd_data_s;

  logic        last_la_r, owner_la_r, abort_r;
  logic [7:0]  tmo_cnt_r, tmo_total_r;
  logic        dev_stb_r, dev_we_r;
  logic [3:0]  dev_sel_r;
  logic [31:0] dev_adr_r, dev_dat_r;
  logic        wbs_ack_r, la_ack_r, timeout_r;
  logic [31:0] wbs_dat_r, la_dat_r;

  // Next-state and grant/completion decode.
  always_comb begin
    wb_req_s    = bus.wbs_cyc_i & bus.wbs_stb_i;
    la_req_s    = bus.la_req_i;
    keep_s      = owner_la_r ? bus.la_req_i : bus.wbs_cyc_i;
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_la_s  = 1'b0;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (wb_req_s || la_req_s) begin
          grant_s     = 1'b1;
          // On a tie, the requester that did not win last time goes first.
          grant_la_s  = la_req_s & (~wb_req_s | ~last_la_r);
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        if (bus.dev_ack_i) begin
          done_s      = 1'b1;
          state_nxt_s = RESP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          done_s      = 1'b1;
          tmo_s       = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = XFER;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    deliver_s = keep_s & ~abort_r;
    rd_data_s = tmo_s ? ERR_DATA : bus.dev_dat_i;
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: latch the winner, time the transfer, return response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_la_r   <= 1'b1;
      owner_la_r  <= 1'b0;
      abort_r     <= 1'b0;
      tmo_cnt_r   <= 8'd0;
      tmo_total_r <= 8'd0;
      dev_stb_r   <= 1'b0;
      dev_we_r    <= 1'b0;
      dev_sel_r   <= 4'd0;
      dev_adr_r   <= 32'd0;
      dev_dat_r   <= 32'd0;
      wbs_ack_r   <= 1'b0;
      la_ack_r    <= 1'b0;
      timeout_r   <= 1'b0;
      wbs_dat_r   <= 32'd0;
      la_dat_r    <= 32'd0;
    end else begin
      wbs_ack_r <= 1'b0;
      la_ack_r  <= 1'b0;
      timeout_r <= 1'b0;
      if (grant_s) begin
        last_la_r  <= grant_la_s;
        owner_la_r <= grant_la_s;
        abort_r    <= 1'b0;
        tmo_cnt_r  <= 8'd0;
        dev_stb_r  <= 1'b1;
        if (grant_la_s) begin
          dev_we_r  <= bus.la_we_i;
          dev_sel_r <= 4'hF;
          dev_adr_r <= bus.la_adr_i;
          dev_dat_r <= bus.la_dat_i;
        end else begin
          dev_we_r  <= bus.wbs_we_i;
          dev_sel_r <= bus.wbs_sel_i;
          dev_adr_r <= bus.wbs_adr_i;
          dev_dat_r <= bus.wbs_dat_i;
        end
      end else if (done_s) begin
        dev_stb_r <= 1'b0;
        if (tmo_s) begin
          timeout_r <= 1'b1;
          if (tmo_total_r != 8'hFF) begin
            tmo_total_r <= tmo_total_r + 8'd1;
          end
        end
        // A requester that let go mid-transfer gets neither ack nor data.
        if (deliver_s) begin
          if (owner_la_r) begin
            la_ack_r <= 1'b1;
            if (!dev_we_r) begin
              la_dat_r <= rd_data_s;
            end
          end else begin
            wbs_ack_r <= 1'b1;
            if (!dev_we_r) begin
              wbs_dat_r <= rd_data_s;
            end
          end
        end
      end else if (state_r == XFER) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
        if (!keep_s) begin
          abort_r <= 1'b1;
        end
      end
    end
  end

  assign bus.dev_stb_o  = dev_stb_r;
  assign bus.dev_we_o   = dev_we_r;
  assign bus.dev_sel_o  = dev_sel_r;
  assign bus.dev_adr_o  = dev_adr_r;
  assign bus.dev_dat_o  = dev_dat_r;
  assign bus.wbs_ack_o  = wbs_ack_r;
  assign bus.wbs_dat_o  = wbs_dat_r;
  assign bus.la_ack_o   = la_ack_r;
  assign bus.la_dat_o   = la_dat_r;
  assign timeout_o      = timeout_r;
  assign timeout_cnt_o  = tmo_total_r;

endmodule

// File: tb/tb_team_03_bus_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for team_03_bus_arbiter: randomized rounds plus directed
// corner cases, expectations derived from the arbitration/timeout rules.
module tb_team_03_bus_arbiter;
  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct {
    bit          la;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          lat;   // stb cycle on which the device acks; 0 = never
    logic [31:0] rdata;
  } txn_t;
  typedef struct { logic [31:0] adr; logic [3:0] sel; bit we; logic [31:0] dat; int len; } dev_exp_t;
  typedef struct { int lat; logic [31:0] rdata; } dev_rsp_t;
  typedef struct { bit la; logic [31:0] dat; bit tmo; logic [7:0] cnt; } resp_exp_t;

  logic       clk;
  logic       rst;
  logic       timeout;
  logic [7:0] timeout_cnt;

  team_03_bus_arbiter_if bus();

  team_03_bus_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .bus           (bus),
    .timeout_o     (timeout),
    .timeout_cnt_o (timeout_cnt)
  );

  dev_exp_t  dev_q[$];
  dev_rsp_t  rsp_q[$];
  resp_exp_t resp_q[$];

  bit          m_last_la;
  logic [7:0]  m_cnt;
  logic [31:0] m_wb_dat, m_la_dat;
  int          n_checks, n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic txn_t mk(input bit la, input bit we, input logic [3:0] sel, input logic [31:0] adr,
                              input logic [31:0] dat, input int lat, input logic [31:0] rdata);
    txn_t t;
    t.la = la; t.we = we; t.sel = sel; t.adr = adr; t.dat = dat; t.lat = lat; t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit la);
    int lat;
    if ($urandom_range(0, 7) != 0) lat = $urandom_range(1, TMO);
    else if ($urandom_range(0, 1) == 0) lat = 0;
    else lat = TMO + 1;
    return mk(la, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, lat, $urandom);
  endfunction

  // Reference model: what the device sees and what the requester gets back.
  task automatic expect_txn(input txn_t t, input bit suppressed);
    dev_exp_t  d;
    dev_rsp_t  r;
    resp_exp_t e;
    bit        to;
    to    = (t.lat < 1) || (t.lat > TMO);
    d.adr = t.adr;
    d.sel = t.la ? 4'hF : t.sel;
    d.we  = t.we;
    d.dat = t.dat;
    d.len = to ? TMO : t.lat;
    dev_q.push_back(d);
    r.lat   = t.lat;
    r.rdata = t.rdata;
    rsp_q.push_back(r);
    if (to && m_cnt != 8'd255) m_cnt++;
    m_last_la = t.la;
    if (!suppressed) begin
      if (!t.we) begin
        if (t.la) m_la_dat = to ? ERR : t.rdata;
        else      m_wb_dat = to ? ERR : t.rdata;
      end
      e.la  = t.la;
      e.dat = t.la ? m_la_dat : m_wb_dat;
      e.tmo = to;
      e.cnt = m_cnt;
      resp_q.push_back(e);
    end
  endtask

  task automatic drive_wb(input txn_t t);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = t.we;
    bus.wbs_sel_i = t.sel; bus.wbs_adr_i = t.adr; bus.wbs_dat_i = t.dat;
  endtask

  task automatic drive_la(input txn_t t);
    bus.la_req_i = 1'b1; bus.la_we_i = t.we; bus.la_adr_i = t.adr; bus.la_dat_i = t.dat;
  endtask

  task automatic wait_acks(input bit wb_in, input bit la_in);
    bit wb_act, la_act;
    int budget;
    wb_act = wb_in;
    la_act = la_in;
    budget = 0;
    while ((wb_act || la_act) && budget < 200) begin
      if (wb_act && bus.wbs_ack_o) begin wb_act = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; end
      if (la_act && bus.la_ack_o)  begin la_act = 1'b0; bus.la_req_i = 1'b0; end
      if (wb_act || la_act) begin @(negedge clk); budget++; end
    end
    if (budget >= 200) fail_now("ack_wait_expired");
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.la_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_round(input bit use_wb, input bit use_la, input txn_t wt, input txn_t lt);
    if (use_wb && use_la) begin
      if (m_last_la) begin expect_txn(wt, 1'b0); expect_txn(lt, 1'b0); end
      else begin expect_txn(lt, 1'b0); expect_txn(wt, 1'b0); end
    end else if (use_wb) expect_txn(wt, 1'b0);
    else if (use_la) expect_txn(lt, 1'b0);
    if (use_wb) drive_wb(wt);
    if (use_la) drive_la(lt);
    @(negedge clk);
    chk("req_to_stb_latency", 32'(bus.dev_stb_o), 32'd1);
    wait_acks(use_wb, use_la);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_dev_stb", 32'(bus.dev_stb_o), 32'd0);
    chk("rst_dev_we", 32'(bus.dev_we_o), 32'd0);
    chk("rst_dev_sel", 32'(bus.dev_sel_o), 32'd0);
    chk("rst_dev_adr", bus.dev_adr_o, 32'd0);
    chk("rst_dev_dat", bus.dev_dat_o, 32'd0);
    chk("rst_wbs_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rst_la_ack", 32'(bus.la_ack_o), 32'd0);
    chk("rst_wbs_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_la_dat", bus.la_dat_o, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
  endtask

  task automatic model_reset();
    m_last_la = 1'b1;
    m_cnt     = 8'd0;
    m_wb_dat  = 32'd0;
    m_la_dat  = 32'd0;
  endtask

  // Device model: acks on the programmed stb cycle, random read data otherwise.
  int       dev_k;
  dev_rsp_t dev_cur;
  initial begin
    dev_k = 0;
    dev_cur.lat = 0;
    dev_cur.rdata = 32'd0;
    bus.dev_ack_i = 1'b0;
    bus.dev_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.dev_stb_o && !rst) begin
        if (dev_k == 0) begin
          if (rsp_q.size() > 0) dev_cur = rsp_q.pop_front();
          else dev_cur.lat = 0;
        end
        dev_k++;
        bus.dev_ack_i = (dev_cur.lat == dev_k);
        bus.dev_dat_i = (dev_cur.lat == dev_k) ? dev_cur.rdata : $urandom;
      end else begin
        dev_k = 0;
        bus.dev_ack_i = 1'b0;
      end
    end
  end

  // Monitor: device-side fields and stb length, requester responses.
  bit        prev_stb;
  int        stb_len;
  dev_exp_t  cur_dev;
  resp_exp_t r_exp;
  initial begin
    prev_stb = 1'b0;
    stb_len  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stb = 1'b0;
        stb_len  = 0;
      end else begin
        if (bus.dev_stb_o && !prev_stb) begin
          stb_len = 0;
          if (dev_q.size() == 0) fail_now("unexpected_dev_stb");
          else cur_dev = dev_q.pop_front();
        end
        if (bus.dev_stb_o) begin
          stb_len++;
          chk("dev_adr", bus.dev_adr_o, cur_dev.adr);
          chk("dev_sel", 32'(bus.dev_sel_o), 32'(cur_dev.sel));
          chk("dev_we", 32'(bus.dev_we_o), 32'(cur_dev.we));
          chk("dev_dat", bus.dev_dat_o, cur_dev.dat);
        end
        if (!bus.dev_stb_o && prev_stb) chk("dev_stb_len", 32'(stb_len), 32'(cur_dev.len));
        if (bus.wbs_ack_o || bus.la_ack_o) begin
          chk("ack_after_stb_fall", 32'({prev_stb, bus.dev_stb_o}), 32'd2);
          chk("one_ack_only", 32'(bus.wbs_ack_o & bus.la_ack_o), 32'd0);
          if (resp_q.size() == 0) fail_now("unexpected_ack");
          else begin
            r_exp = resp_q.pop_front();
            chk("ack_owner_la", 32'(bus.la_ack_o), 32'(r_exp.la));
            chk("resp_data", r_exp.la ? bus.la_dat_o : bus.wbs_dat_o, r_exp.dat);
            chk("timeout_pulse", 32'(timeout), 32'(r_exp.tmo));
            chk("timeout_cnt", 32'(timeout_cnt), 32'(r_exp.cnt));
          end
        end else if (timeout) begin
          fail_now("timeout_without_ack");
        end
        prev_stb = bus.dev_stb_o;
      end
    end
  end

  txn_t wt, lt;
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'd0;
    bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    bus.la_req_i = 1'b0; bus.la_we_i = 1'b0; bus.la_adr_i = 32'd0; bus.la_dat_i = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // WB read with the device acking on the second stb cycle.
    wt = mk(1'b0, 1'b0, 4'hF, 32'h3000_0004, 32'd0, 2, 32'h1234_5678);
    do_round(1'b1, 1'b0, wt, lt);
    chk("wb_read_data_held", bus.wbs_dat_o, 32'h1234_5678);

    // Back-to-back ties alternate the winner.
    repeat (3) do_round(1'b1, 1'b1, rand_txn(1'b0), rand_txn(1'b1));

    // Ack exactly on the last allowed cycle, one before, and one too late.
    do_round(1'b0, 1'b1, lt, mk(1'b1, 1'b0, 4'h0, $urandom, $urandom, TMO, 32'hCAFE_0016));
    do_round(1'b1, 1'b0, mk(1'b0, 1'b0, 4'h3, $urandom, $urandom, TMO - 1, 32'hCAFE_0015), lt);
    do_round(1'b0, 1'b1, lt, mk(1'b1, 1'b0, 4'h0, $urandom, $urandom, TMO + 1, 32'hCAFE_0017));

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0:       do_round(1'b1, 1'b0, rand_txn(1'b0), lt);
        1:       do_round(1'b0, 1'b1, wt, rand_txn(1'b1));
        default: do_round(1'b1, 1'b1, rand_txn(1'b0), rand_txn(1'b1));
      endcase
    end

    // Enough LA-write timeouts to saturate the counter.
    for (int i = 0; i < 260; i++) begin
      do_round(1'b0, 1'b1, wt, mk(1'b1, 1'b1, 4'h0, $urandom, $urandom, 0, 32'd0));
    end
    chk("timeout_cnt_saturated", 32'(timeout_cnt), 32'd255);

    // WB withdraws mid-transfer while LA waits.
    wt = mk(1'b0, 1'b0, 4'hA, 32'h3000_0100, 32'd0, $urandom_range(3, TMO), 32'h5555_AAAA);
    lt = rand_txn(1'b1);
    lt.lat = $urandom_range(1, TMO);
    expect_txn(wt, 1'b1);
    expect_txn(lt, 1'b0);
    drive_wb(wt);
    @(negedge clk);
    chk("abort_req_to_stb", 32'(bus.dev_stb_o), 32'd1);
    drive_la(lt);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    wait_acks(1'b0, 1'b1);

    // Reset in the middle of a transfer.
    wt = mk(1'b0, 1'b0, 4'h5, 32'h3000_0200, 32'd0, 0, 32'd0);
    expect_txn(wt, 1'b1);
    drive_wb(wt);
    repeat (4) @(negedge clk);
    chk("pre_reset_stb", 32'(bus.dev_stb_o), 32'd1);
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // After reset the WB side wins the first tie again.
    do_round(1'b1, 1'b1, rand_txn(1'b0), rand_txn(1'b1));

    chk("dev_queue_drained", 32'(dev_q.size()), 32'd0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
